// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 4-digit seven-segment scan controller with frame-synchronous shadow update.
// Optional build macro LEADING_ZERO_SUPPRESS_EN darkens leading zero digits 3..1.
module display_scan_ctrl #(
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        En,
  input  logic        Load,
  input  logic [15:0] Value,
  input  logic [3:0]  DpIn,
  input  logic [3:0]  BlankMask,
  output logic [3:0]  An,
  output logic [6:0]  Seg,
  output logic        Dp,
  output logic        FrameDone,
  output logic        LoadAck
);

  localparam int MAX_CNT = (PRESCALE > BLANK_CYC) ? PRESCALE : BLANK_CYC;
  localparam int CW      = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] LIT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam bit HAS_GAP = (BLANK_CYC > 0);

  typedef enum logic [1:0] {IDLE, LIT, GAP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic [15:0]     pend_value_q, pend_value_d;
  logic [3:0]      pend_dp_q, pend_dp_d;
  logic [3:0]      pend_mask_q, pend_mask_d;
  logic [15:0]     shadow_value_q, shadow_value_d;
  logic [3:0]      shadow_dp_q, shadow_dp_d;
  logic [3:0]      shadow_mask_q, shadow_mask_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic            load_ack_q, load_ack_d;

  logic            frame_end;
  logic            apply;
  logic [3:0]      digit;
  logic [3:0]      lz;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
    case (d)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  // Frame ends on the last cycle of digit 3's gap, or its lit slot when there is no gap.
  always_comb begin
    frame_end = 1'b0;
    if (idx_q == 2'd3) begin
      if (HAS_GAP) frame_end = (state_q == GAP) && (cnt_q == GAP_LAST);
      else         frame_end = (state_q == LIT) && (cnt_q == LIT_LAST);
    end
    apply = pend_q && ((state_q == IDLE) || frame_end);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!En) begin
      state_d = IDLE;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = LIT;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
        LIT: begin
          if (cnt_q == LIT_LAST) begin
            cnt_d = '0;
            if (HAS_GAP) state_d = GAP;
            else         idx_d   = idx_q + 2'd1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = LIT;
            idx_d   = idx_q + 2'd1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A Load on the apply edge stays pending; the older pending data is what gets applied.
  always_comb begin
    pend_d         = pend_q;
    pend_value_d   = pend_value_q;
    pend_dp_d      = pend_dp_q;
    pend_mask_d    = pend_mask_q;
    shadow_value_d = shadow_value_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_mask_d  = shadow_mask_q;
    load_ack_d     = 1'b0;
    if (apply) begin
      shadow_value_d = pend_value_q;
      shadow_dp_d    = pend_dp_q;
      shadow_mask_d  = pend_mask_q;
      load_ack_d     = 1'b1;
      pend_d         = 1'b0;
    end
    if (Load) begin
      pend_d       = 1'b1;
      pend_value_d = Value;
      pend_dp_d    = DpIn;
      pend_mask_d  = BlankMask;
    end
  end

  always_comb begin
    lz = 4'b0000;
`ifdef LEADING_ZERO_SUPPRESS_EN
    lz[3] = (shadow_value_d[15:12] == 4'h0);
    lz[2] = lz[3] && (shadow_value_d[11:8] == 4'h0);
    lz[1] = lz[2] && (shadow_value_d[7:4] == 4'h0);
`else
    lz = 4'b0000;
`endif
    digit = shadow_value_d[{idx_d, 2'b00} +: 4];
    an_d  = 4'b1111;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if ((state_d == LIT) && !shadow_mask_d[idx_d] && !lz[idx_d]) begin
      an_d  = ~(4'b0001 << idx_d);
      seg_d = hex_to_seg(digit);
      dp_d  = ~shadow_dp_d[idx_d];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= IDLE;
      idx_q          <= 2'd0;
      cnt_q          <= '0;
      pend_q         <= 1'b0;
      pend_value_q   <= 16'h0000;
      pend_dp_q      <= 4'h0;
      pend_mask_q    <= 4'h0;
      shadow_value_q <= 16'h0000;
      shadow_dp_q    <= 4'h0;
      shadow_mask_q  <= 4'h0;
      an_q           <= 4'b1111;
      seg_q          <= 7'h7F;
      dp_q           <= 1'b1;
      load_ack_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      pend_q         <= pend_d;
      pend_value_q   <= pend_value_d;
      pend_dp_q      <= pend_dp_d;
      pend_mask_q    <= pend_mask_d;
      shadow_value_q <= shadow_value_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_mask_q  <= shadow_mask_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
      load_ack_q     <= load_ack_d;
    end
  end

  assign An        = an_q;
  assign Seg       = seg_q;
  assign Dp        = dp_q;
  assign FrameDone = frame_end;
  assign LoadAck   = load_ack_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: expected per-cycle outputs are queued as stimulus is driven.
module tb_display_scan_ctrl;

  localparam int PRESCALE  = 4;
  localparam int BLANK_CYC = 1;
  localparam int SLOT      = PRESCALE + BLANK_CYC;
  localparam int FRAME     = 4 * SLOT;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        En = 1'b0;
  logic        Load = 1'b0;
  logic [15:0] Value = 16'h0000;
  logic [3:0]  DpIn = 4'h0;
  logic [3:0]  BlankMask = 4'h0;
  logic [3:0]  An;
  logic [6:0]  Seg;
  logic        Dp;
  logic        FrameDone;
  logic        LoadAck;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    logic       ack;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  display_scan_ctrl #(.PRESCALE(PRESCALE), .BLANK_CYC(BLANK_CYC)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Load(Load), .Value(Value), .DpIn(DpIn),
    .BlankMask(BlankMask), .An(An), .Seg(Seg), .Dp(Dp), .FrameDone(FrameDone), .LoadAck(LoadAck)
  );

  always #5 Clk = ~Clk;

  task automatic push_dark(input int n, input logic ack_first);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.fd = 1'b0;
      e.ack = (i == 0) && ack_first;
      sb.push_back(e);
    end
  endtask

  // Expected first n cycles of a frame showing value v.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] mask,
                            input logic ack_first, input int n);
    exp_t e;
    logic [3:0] lz;
    logic [3:0] nib;
    logic [3:0] one;
    int k;
    k = 0;
    one = 4'b0001;
    lz = 4'b0000;
`ifdef LEADING_ZERO_SUPPRESS_EN
    lz[3] = (v[15:12] == 4'h0);
    lz[2] = lz[3] && (v[11:8] == 4'h0);
    lz[1] = lz[2] && (v[7:4] == 4'h0);
`endif
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < SLOT; c++) begin
        if (k < n) begin
          e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
          if (c < PRESCALE && !mask[d] && !lz[d]) begin
            nib = v[d*4 +: 4];
            e.an  = ~(one << d);
            e.seg = seg_tbl[nib];
            e.dp  = ~dp[d];
          end
          e.fd  = (d == 3) && (c == SLOT - 1);
          e.ack = (k == 0) && ack_first;
          sb.push_back(e);
        end
        k++;
      end
    end
  endtask

  task automatic drain(input int n, input string tag);
    exp_t e;
    exp_t act;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL %s cycle %0d: scoreboard empty, got an=%b seg=%h", tag, i, An, Seg);
      end else begin
        e = sb.pop_front();
        act = {An, Seg, Dp, FrameDone, LoadAck};
        if (act !== e) begin
          failures++;
          $display("FAIL %s cycle %0d: got an=%b seg=%h dp=%b fd=%b ack=%b, want an=%b seg=%h dp=%b fd=%b ack=%b",
                   tag, i, An, Seg, Dp, FrameDone, LoadAck, e.an, e.seg, e.dp, e.fd, e.ack);
        end
      end
    end
  endtask

  task automatic test_reset;
    Load = 1'b1; Value = 16'hFFFF; DpIn = 4'hF;
    push_dark(3, 1'b0);
    drain(3, "reset_hold");
    Reset = 1'b0; Load = 1'b0;
    push_dark(2, 1'b0);
    drain(2, "reset_idle");
    En = 1'b1;
    push_frame(16'h0000, 4'h0, 4'h0, 1'b0, FRAME);
    drain(FRAME, "reset_zero_frame");
    En = 1'b0;
    push_dark(1, 1'b0);
    drain(1, "reset_disable");
  endtask

  task automatic test_basic;
    Load = 1'b1; Value = 16'h1234; DpIn = 4'h0; BlankMask = 4'h0;
    push_dark(1, 1'b0);
    drain(1, "basic_capture");
    Load = 1'b0; En = 1'b1;
    push_frame(16'h1234, 4'h0, 4'h0, 1'b1, FRAME);
    push_frame(16'h1234, 4'h0, 4'h0, 1'b0, FRAME);
    drain(2 * FRAME, "basic_scan");
  endtask

  task automatic test_pending;
    push_frame(16'h1234, 4'h0, 4'h0, 1'b0, FRAME);
    drain(3, "pend_pre");
    Load = 1'b1; Value = 16'hABCD;
    drain(1, "pend_load1");
    Load = 1'b0;
    drain(2, "pend_mid");
    Load = 1'b1; Value = 16'h5678; DpIn = 4'b0010;
    drain(1, "pend_load2");
    Load = 1'b0; DpIn = 4'h0; Value = 16'h0000;
    drain(FRAME - 7, "pend_hold");
    push_frame(16'h5678, 4'b0010, 4'h0, 1'b1, FRAME);
    drain(FRAME, "pend_apply");
  endtask

  task automatic test_back_to_back;
    push_frame(16'h5678, 4'b0010, 4'h0, 1'b0, FRAME);
    drain(FRAME, "b2b_pre");
    Load = 1'b1; Value = 16'h9ABC; DpIn = 4'h0;
    push_frame(16'h5678, 4'b0010, 4'h0, 1'b0, FRAME);
    drain(1, "b2b_load");
    Load = 1'b0;
    drain(FRAME - 1, "b2b_hold");
    push_frame(16'h9ABC, 4'h0, 4'h0, 1'b1, FRAME);
    drain(FRAME, "b2b_apply");
  endtask

  task automatic test_en_drop;
    push_frame(16'h9ABC, 4'h0, 4'h0, 1'b0, 2 * SLOT + 2);
    drain(2 * SLOT + 2, "endrop_pre");
    En = 1'b0;
    push_dark(2, 1'b0);
    drain(2, "endrop_dark");
    En = 1'b1;
    push_frame(16'h9ABC, 4'h0, 4'h0, 1'b0, FRAME);
    drain(FRAME, "endrop_restart");
  endtask

  task automatic test_zero_suppress;
    En = 1'b0;
    push_dark(1, 1'b0);
    drain(1, "lz_idle");
    Load = 1'b1; Value = 16'h0005; DpIn = 4'h0; BlankMask = 4'h0;
    push_dark(1, 1'b0);
    drain(1, "lz_capture");
    Load = 1'b0; Value = 16'hFFFF;
    push_dark(1, 1'b1);
    drain(1, "lz_idle_apply");
    En = 1'b1;
    push_frame(16'h0005, 4'h0, 4'h0, 1'b0, FRAME);
    drain(FRAME, "lz_frame");
  endtask

  task automatic test_mask_dp;
    Load = 1'b1; Value = 16'h8888; DpIn = 4'b0001; BlankMask = 4'b1000;
    push_frame(16'h0005, 4'h0, 4'h0, 1'b0, FRAME);
    drain(1, "mask_load");
    Load = 1'b0; DpIn = 4'h0; BlankMask = 4'h0;
    drain(FRAME - 1, "mask_hold");
    push_frame(16'h8888, 4'b0001, 4'b1000, 1'b1, FRAME);
    drain(FRAME, "mask_frame");
  endtask

  task automatic test_reset_mid_lit;
    push_frame(16'h8888, 4'b0001, 4'b1000, 1'b0, 3);
    drain(3, "rst_pre");
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({An, Seg, Dp, FrameDone, LoadAck} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL rst_async: got an=%b seg=%h dp=%b fd=%b ack=%b, want an=1111 seg=7f dp=1 fd=0 ack=0",
               An, Seg, Dp, FrameDone, LoadAck);
    end
    push_dark(3, 1'b0);
    drain(3, "rst_held");
    Reset = 1'b0; En = 1'b0;
    push_dark(2, 1'b0);
    drain(2, "rst_released");
    En = 1'b1;
    push_frame(16'h0000, 4'h0, 4'h0, 1'b0, FRAME);
    drain(FRAME, "rst_restart");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pending();
    test_back_to_back();
    test_en_drop();
    test_zero_suppress();
    test_mask_dp();
    test_reset_mid_lit();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d entries, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
